// File: rtl/sysid_access_controller_if.sv
// Host-side Avalon-MM read port of the system-ID access controller.
interface sysid_access_controller_if;
  logic        host_read;
  logic        host_address;
  logic        host_waitrequest;
  logic [31:0] host_readdata;
  logic        host_readdatavalid;

  modport master (
    output host_read,
    output host_address,
    input  host_waitrequest,
    input  host_readdata,
    input  host_readdatavalid
  );

  modport slave (
    input  host_read,
    input  host_address,
    output host_waitrequest,
    output host_readdata,
    output host_readdatavalid
  );
endinterface

// File: rtl/sysid_access_controller.sv
// Shares the sysid slave between host reads (fixed latency 2, waitrequest until granted) and an ID/TS
// integrity checker, round-robin. SYSID_PERIODIC_CHECK_EN adds automatic rechecks every RECHECK_PERIOD.
module sysid_access_controller #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1453761516,
  parameter logic [15:0] RECHECK_PERIOD = 16'd1000
) (
  input  logic                            clock,
  input  logic                            reset,
  sysid_access_controller_if.slave        host,
  output logic                            sysid_address,
  input  logic [31:0]                     sysid_readdata,
  input  logic                            start_check,
  output logic                            check_busy,
  output logic                            check_done,
  output logic                            id_ok,
  output logic                            ts_ok
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOST,
    S_CHK_ID,
    S_CHK_TS
  } state_t;

  typedef enum logic {
    G_HOST,
    G_CHK
  } grant_t;

  state_t state;
  state_t state_next;
  grant_t last_grant;

  logic chk_pend;
  logic ts_pend;
  logic id_match;
  logic chk_req;
  logic grant_host;
  logic grant_chk;
  logic periodic_fire;

  assign chk_req = chk_pend | ts_pend;

  always_comb begin
    state_next = state;
    grant_host = 1'b0;
    grant_chk  = 1'b0;
    case (state)
      S_IDLE: begin
        if (host.host_read && chk_req) begin
          if (last_grant == G_HOST) grant_chk  = 1'b1;
          else                      grant_host = 1'b1;
        end else if (host.host_read) begin
          grant_host = 1'b1;
        end else if (chk_req) begin
          grant_chk = 1'b1;
        end
        if (grant_host)     state_next = S_HOST;
        else if (grant_chk) state_next = ts_pend ? S_CHK_TS : S_CHK_ID;
      end
      S_HOST, S_CHK_ID, S_CHK_TS: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Acceptance is combinational in IDLE; reset forces the handshake back to "not accepted".
  assign host.host_waitrequest = reset | ~grant_host;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      last_grant    <= G_HOST;
      sysid_address <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_host) begin
        last_grant    <= G_HOST;
        sysid_address <= host.host_address;
      end else if (grant_chk) begin
        last_grant    <= G_CHK;
        sysid_address <= ts_pend;
      end
    end
  end

  // Checker bookkeeping: a grant that starts a sequence absorbs any same-cycle start request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chk_pend   <= 1'b1;
      ts_pend    <= 1'b0;
      check_busy <= 1'b0;
      id_match   <= 1'b0;
    end else begin
      if (grant_chk && !ts_pend)
        chk_pend <= 1'b0;
      else if ((start_check && !check_busy) || periodic_fire)
        chk_pend <= 1'b1;

      if (state == S_CHK_ID) begin
        ts_pend  <= 1'b1;
        id_match <= (sysid_readdata == EXPECTED_ID);
      end else if (grant_chk && ts_pend) begin
        ts_pend <= 1'b0;
      end

      if (grant_chk && !ts_pend)
        check_busy <= 1'b1;
      else if (state == S_CHK_TS)
        check_busy <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      host.host_readdata      <= 32'd0;
      host.host_readdatavalid <= 1'b0;
      check_done              <= 1'b0;
      id_ok                   <= 1'b0;
      ts_ok                   <= 1'b0;
    end else begin
      host.host_readdatavalid <= (state == S_HOST);
      if (state == S_HOST)
        host.host_readdata <= sysid_readdata;
      check_done <= (state == S_CHK_TS);
      if (state == S_CHK_TS) begin
        id_ok <= id_match;
        ts_ok <= (sysid_readdata == EXPECTED_TS);
      end
    end
  end

`ifdef SYSID_PERIODIC_CHECK_EN
  logic [15:0] recheck_cnt;
  logic        recheck_armed;

  // The armed flag makes the zero count fire once per completed check; a busy checker defers it.
  assign periodic_fire = recheck_armed && (recheck_cnt == 16'd0) && !check_busy && !check_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      recheck_cnt   <= 16'd0;
      recheck_armed <= 1'b0;
    end else if (check_done) begin
      recheck_cnt   <= RECHECK_PERIOD;
      recheck_armed <= (RECHECK_PERIOD != 16'd0);
    end else begin
      if (recheck_cnt != 16'd0)
        recheck_cnt <= recheck_cnt - 16'd1;
      if (periodic_fire)
        recheck_armed <= 1'b0;
    end
  end
`else
  logic unused_recheck_period;
  assign unused_recheck_period = ^RECHECK_PERIOD;
  assign periodic_fire         = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_access_controller.sv
// Scenario bench for sysid_access_controller with a combinational sysid model and a host read scoreboard.
module tb_sysid_access_controller;
  localparam logic [31:0] TS_GOOD = 32'd1453761516;
  localparam logic [31:0] TS_BAD  = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        sysid_address;
  logic [31:0] sysid_readdata;
  logic        start_check;
  logic        check_busy;
  logic        check_done;
  logic        id_ok;
  logic        ts_ok;
  logic [31:0] id_val;
  logic [31:0] ts_val;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_count = 0;
  int rdv_count = 0;
  logic [31:0] exp_q [$];
  int          exp_cyc_q [$];

  sysid_access_controller_if host ();

  sysid_access_controller dut (
    .clock          (clock),
    .reset          (reset),
    .host           (host),
    .sysid_address  (sysid_address),
    .sysid_readdata (sysid_readdata),
    .start_check    (start_check),
    .check_busy     (check_busy),
    .check_done     (check_done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign sysid_readdata = sysid_address ? ts_val : id_val;

  // Scoreboard: an accepted read must return the modelled word exactly two cycles later.
  always @(negedge clock) begin
    logic [31:0] e;
    int          c;
    if (!reset && host.host_read && !host.host_waitrequest) begin
      exp_q.push_back(host.host_address ? ts_val : id_val);
      exp_cyc_q.push_back(cyc + 2);
      acc_count++;
    end
    if (host.host_readdatavalid) begin
      rdv_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL host_rdv_unexpected: readdata=%h at cycle %0d, no accepted request", host.host_readdata, cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (host.host_readdata !== e || cyc !== c) begin
          bad++;
          $display("FAIL host_rdata: got %h at cycle %0d, want %h at cycle %0d", host.host_readdata, cyc, e, c);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (check_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start;
    @(posedge clock); #1 start_check = 1'b1;
    @(posedge clock); #1 start_check = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    host.host_read = 1'b1;
    host.host_address = 1'b1;
    start_check = 1'b0;
    id_val = 32'd0;
    ts_val = TS_GOOD;
    repeat (2) @(negedge clock);
    total++; if (host.host_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_waitrequest: got %b want 1", host.host_waitrequest); end
    total++; if (host.host_readdata !== 32'd0) begin bad++; $display("FAIL rst_readdata: got %h want 0", host.host_readdata); end
    total++; if (host.host_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv: got %b want 0", host.host_readdatavalid); end
    total++; if (sysid_address !== 1'b0) begin bad++; $display("FAIL rst_sysid_address: got %b want 0", sysid_address); end
    total++; if ({check_busy, check_done, id_ok, ts_ok} !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b want 0000", {check_busy, check_done, id_ok, ts_ok}); end
    host.host_read = 1'b0;
  endtask

  task automatic test_boot_check;
    logic addr_h [0:9];
    logic done_h [0:9];
    logic busy_h [0:9];
    logic idok_h [0:9];
    logic tsok_h [0:9];
    int d;
    int ndone;
    @(posedge clock); #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      addr_h[k] = sysid_address;
      done_h[k] = check_done;
      busy_h[k] = check_busy;
      idok_h[k] = id_ok;
      tsok_h[k] = ts_ok;
    end
    d = -1;
    ndone = 0;
    for (int k = 0; k < 10; k++) if (done_h[k]) begin ndone++; if (d < 0) d = k; end
    total++; if (ndone != 1) begin bad++; $display("FAIL boot_done_count: got %0d want 1", ndone); end
    total++; if (d < 2 || d > 5) begin bad++; $display("FAIL boot_done_latency: got cycle %0d want 2..5", d); end
    total++; if (addr_h[1] !== 1'b0 || busy_h[1] !== 1'b1) begin bad++; $display("FAIL boot_id_access: addr=%b busy=%b want addr=0 busy=1", addr_h[1], busy_h[1]); end
    if (d >= 2) begin
      total++; if (addr_h[d-1] !== 1'b1) begin bad++; $display("FAIL boot_ts_addr: got %b want 1", addr_h[d-1]); end
      total++; if (busy_h[d-1] !== 1'b1 || busy_h[d] !== 1'b0) begin bad++; $display("FAIL boot_busy_fall: got %b%b want 10", busy_h[d-1], busy_h[d]); end
      total++; if (idok_h[d-1] !== 1'b0) begin bad++; $display("FAIL boot_flag_early: id_ok got %b want 0 before done", idok_h[d-1]); end
      total++; if (idok_h[d] !== 1'b1 || tsok_h[d] !== 1'b1) begin bad++; $display("FAIL boot_flags: got id=%b ts=%b want 1 1", idok_h[d], tsok_h[d]); end
    end
  endtask

  task automatic test_bad_ts;
    int n;
    ts_val = TS_BAD;
    pulse_start();
    wait_done(20, n);
    total++; if (n < 0) begin bad++; $display("FAIL badts_timeout: no check_done in 20 cycles"); end
    total++; if (id_ok !== 1'b1 || ts_ok !== 1'b0) begin bad++; $display("FAIL badts_flags: got id=%b ts=%b want 1 0", id_ok, ts_ok); end
    ts_val = TS_GOOD;
    pulse_start();
    wait_done(20, n);
    total++; if (n < 0) begin bad++; $display("FAIL goodts_timeout: no check_done in 20 cycles"); end
    total++; if (id_ok !== 1'b1 || ts_ok !== 1'b1) begin bad++; $display("FAIL goodts_flags: got id=%b ts=%b want 1 1", id_ok, ts_ok); end
  endtask

  task automatic test_host_read;
    int rdv0;
    rdv0 = rdv_count;
    repeat (3) @(negedge clock);
    for (int a = 1; a >= 0; a--) begin
      @(posedge clock); #1 host.host_read = 1'b1; host.host_address = a[0];
      @(negedge clock);
      total++; if (host.host_waitrequest !== 1'b0) begin bad++; $display("FAIL host_idle_accept: waitrequest got %b want 0", host.host_waitrequest); end
      @(posedge clock); #1 host.host_read = 1'b0;
      repeat (3) @(negedge clock);
    end
    total++; if (rdv_count - rdv0 != 2 || exp_q.size() != 0) begin bad++; $display("FAIL host_rdv_count: got %0d pending=%0d want 2 pending=0", rdv_count - rdv0, exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] wr_h;
    logic       addr_h [0:9];
    logic       done_h [0:9];
    int acc0;
    int rdv0;
    @(posedge clock); #1 reset = 1'b1; host.host_read = 1'b1; host.host_address = 1'b0;
    acc0 = acc_count;
    rdv0 = rdv_count;
    @(posedge clock); #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      wr_h[k]   = host.host_waitrequest;
      addr_h[k] = sysid_address;
      done_h[k] = check_done;
    end
    @(posedge clock); #1 host.host_read = 1'b0;
    repeat (4) @(negedge clock);
    // Grants: CHK_ID (p0), HOST (p2), CHK_TS (p4), HOST (p6), HOST (p8).
    total++; if (wr_h !== 10'b10_1011_1011) begin bad++; $display("FAIL b2b_waitrequest: got %b want 1010111011 (bit k = cycle k)", wr_h); end
    total++; if (addr_h[1] !== 1'b0 || addr_h[3] !== 1'b0 || addr_h[5] !== 1'b1) begin bad++; $display("FAIL b2b_address: got %b%b%b want 001", addr_h[1], addr_h[3], addr_h[5]); end
    total++; if (done_h[6] !== 1'b1) begin bad++; $display("FAIL b2b_done: check_done at cycle 6 got %b want 1", done_h[6]); end
    total++; if (acc_count - acc0 != 3 || rdv_count - rdv0 != 3) begin bad++; $display("FAIL b2b_counts: accepted=%0d valid=%0d want 3 3", acc_count - acc0, rdv_count - rdv0); end
  endtask

  task automatic test_busy_ignore;
    int found;
    int cnt;
    pulse_start();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (check_busy) begin found = 1; break; end
    end
    total++; if (found != 1) begin bad++; $display("FAIL busy_rise: check_busy got 0 want 1 within 10 cycles"); end
    @(posedge clock); #1 start_check = 1'b1;
    @(posedge clock); #1 start_check = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (check_done) cnt++;
    end
    total++; if (cnt != 1) begin bad++; $display("FAIL busy_ignore: check_done count got %0d want 1", cnt); end
  endtask

  task automatic test_reset_mid;
    int n;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (check_busy) break;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if ({check_busy, id_ok, ts_ok} !== 3'b000 || host.host_waitrequest !== 1'b1) begin bad++; $display("FAIL midrst_flags: busy/id/ts got %b wr=%b want 000 wr=1", {check_busy, id_ok, ts_ok}, host.host_waitrequest); end
    @(posedge clock); #1 reset = 1'b0;
    wait_done(10, n);
    total++; if (n < 0 || n > 5) begin bad++; $display("FAIL midrst_recheck: done after %0d cycles want 0..5", n); end
    total++; if (id_ok !== 1'b1 || ts_ok !== 1'b1) begin bad++; $display("FAIL midrst_flags_after: got id=%b ts=%b want 1 1", id_ok, ts_ok); end
  endtask

  task automatic test_periodic;
    int n;
    int cnt;
`ifdef SYSID_PERIODIC_CHECK_EN
    cnt = 0;
    wait_done(1200, n);
    total++; if (n < 0) begin bad++; $display("FAIL periodic_recheck: no automatic check_done in 1200 cycles"); end
`else
    n = 0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (check_done) cnt++;
    end
    total++; if (cnt != n) begin bad++; $display("FAIL no_periodic: check_done count got %0d want 0", cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_boot_check();
    test_bad_ts();
    test_host_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_periodic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
